// File: rtl/vm_pkg.sv
// -----------------------------------------------------------------------------
// vm_pkg
// Shared definitions for the parametrised vending controller:
//   - vm_state_e : controller FSM state encoding
//   - COIN_*     : coin acceptor codes
//   - price_of() : extracts one price entry from the packed price vector
// No ports (package).
// -----------------------------------------------------------------------------
package vm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_VEND    = 2'd2,
      ST_CHANGE  = 2'd3
   } vm_state_e;

   localparam logic [1:0] COIN_NONE = 2'b00;
   localparam logic [1:0] COIN_1    = 2'b01;
   localparam logic [1:0] COIN_2    = 2'b10;
   localparam logic [1:0] COIN_3    = 2'b11;

   // Widest packed price vector price_of() accepts; callers zero-extend.
   localparam int PRICES_MAX_W = 256;

   function automatic logic [31:0] price_of(input logic [PRICES_MAX_W-1:0] prices,
                                            input int unsigned              idx,
                                            input int unsigned              price_w);
      logic [PRICES_MAX_W-1:0] mask;
      logic [PRICES_MAX_W-1:0] field;
      mask  = (PRICES_MAX_W'(1) << price_w) - PRICES_MAX_W'(1);
      field = (prices >> (idx * price_w)) & mask;
      return 32'(field);
   endfunction

endpackage

// File: rtl/vm_if.sv
// -----------------------------------------------------------------------------
// vm_if
// Front-end / dispenser bus of the vending controller.
//   master : keypad + coin acceptor side (drives coin, sel_valid, sel, cancel,
//            restock; observes all status outputs)
//   slave  : the controller itself
// Signals:
//   coin[1:0]           coin code, 2'b00 = none
//   sel_valid, sel      one-cycle product selection strobe and index
//   cancel              refund request
//   restock             reload stock counters
//   vend[NUM_PROD]      one-hot vend pulse
//   change              one change unit returned this cycle
//   credit[CREDIT_W]    current credit
//   busy                vend or change in progress
//   coin_reject         coin presented this cycle is returned
//   sel_err             selection refused (pulse)
//   sold_out[NUM_PROD]  per-product empty flag
// -----------------------------------------------------------------------------
interface vm_if #(
   parameter int NUM_PROD = 4,
   parameter int SEL_W    = 2,
   parameter int CREDIT_W = 8
);
   logic [1:0]          coin;
   logic                sel_valid;
   logic [SEL_W-1:0]    sel;
   logic                cancel;
   logic                restock;
   logic [NUM_PROD-1:0] vend;
   logic                change;
   logic [CREDIT_W-1:0] credit;
   logic                busy;
   logic                coin_reject;
   logic                sel_err;
   logic [NUM_PROD-1:0] sold_out;

   modport master (
      output coin, sel_valid, sel, cancel, restock,
      input  vend, change, credit, busy, coin_reject, sel_err, sold_out
   );

   modport slave (
      input  coin, sel_valid, sel, cancel, restock,
      output vend, change, credit, busy, coin_reject, sel_err, sold_out
   );
endinterface

// File: rtl/vm_change_dispenser.sv
// -----------------------------------------------------------------------------
// vm_change_dispenser
// Loads an amount and emits one change pulse per cycle, each worth CHG_UNIT,
// until less than CHG_UNIT remains. o_done marks the last pulse of a train.
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-low reset (aborts any train in progress)
//   i_load    load i_amount; pulses start the following cycle
//   i_amount  amount to return
//   o_change  one-unit change pulse
//   o_done    high together with the final pulse
// -----------------------------------------------------------------------------
module vm_change_dispenser #(
   parameter int CREDIT_W = 8,
   parameter int CHG_UNIT = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_load,
   input  logic [CREDIT_W-1:0] i_amount,
   output logic                o_change,
   output logic                o_done
);

   localparam int AMT_W = CREDIT_W + 2;

   logic [CREDIT_W-1:0] r_amt;
   logic                r_active;
   logic                w_last;

   // Last pulse when what would remain afterwards is below one unit.
   assign w_last = {2'b00, r_amt} < AMT_W'(2 * CHG_UNIT);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_amt    <= '0;
         r_active <= 1'b0;
      end else if (i_load) begin
         r_amt    <= i_amount;
         r_active <= (i_amount >= CREDIT_W'(CHG_UNIT));
      end else if (r_active) begin
         r_amt    <= r_amt - CREDIT_W'(CHG_UNIT);
         r_active <= !w_last;
      end
   end

   assign o_change = r_active;
   assign o_done   = r_active & w_last;

endmodule

// File: rtl/vending_machine_param.sv
// -----------------------------------------------------------------------------
// vending_machine_param
// Parametrised multi-product vending controller. Accumulates coin credit,
// vends the selected product when credit covers its price and returns change
// as a train of one-unit pulses through vm_change_dispenser.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-low reset
//   bus    vm_if.slave (coin/keypad inputs, vend/change/status outputs)
// Build option:
//   VM_STOCK_TRACK_EN  per-product stock counters, sold_out flags and restock.
//                      Undefined: sold_out tied low, restock ignored.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | credit 0, waiting for the first coin
// ST_COLLECT | credit > 0, accepting coins / selection / cancel
// ST_VEND    | one cycle, vend pulse on the output
// ST_CHANGE  | returning credit one CHG_UNIT per cycle
// -----------------------------------------------------------------------------
module vending_machine_param
   import vm_pkg::*;
#(
   parameter int                          NUM_PROD   = 4,
   parameter int                          SEL_W      = 2,
   parameter int                          CREDIT_W   = 8,
   parameter int                          PRICE_W    = 8,
   parameter logic [NUM_PROD*PRICE_W-1:0] PRICES     = 32'h19140F0A,
   parameter int                          COIN1_VAL  = 5,
   parameter int                          COIN2_VAL  = 10,
   parameter int                          COIN3_VAL  = 25,
   parameter int                          CHG_UNIT   = 5,
   parameter int                          STOCK_W    = 4,
   parameter int                          STOCK_INIT = 8
) (
   input logic clk,
   input logic reset,
   vm_if.slave bus
);

   localparam int MAX_CREDIT = 2**CREDIT_W - 1;
   localparam int SUM_W      = CREDIT_W + 1;
   localparam int SEL_SPAN   = 2**SEL_W;

   vm_state_e           r_state;
   vm_state_e           w_state_nxt;
   logic [CREDIT_W-1:0] r_credit;
   logic [NUM_PROD-1:0] r_vend;
   logic                r_sel_err;

   logic                w_front;
   logic                w_cancel_acc;
   logic                w_sel_take;
   logic                w_sel_ok;
   logic                w_sel_bad;
   logic                w_sel_in_range;
   logic [31:0]         w_price;
   logic                w_price_ok;
   logic [SUM_W-1:0]    w_coin_val;
   logic [SUM_W-1:0]    w_sum;
   logic                w_coin_acc;
   logic                w_chg_ok;
   logic                w_load;
   logic                w_change;
   logic                w_done;
   logic                w_busy;
   logic                w_coin_reject;
   logic [NUM_PROD-1:0] w_sold_out;
   logic [SEL_SPAN-1:0] w_sold_ext;

   // ---------------------------------------------------------------- decode
   assign w_front        = (r_state == ST_IDLE) || (r_state == ST_COLLECT);
   assign w_cancel_acc   = (r_state == ST_COLLECT) && bus.cancel;
   // An accepted cancel swallows a simultaneous selection.
   assign w_sel_take     = w_front && bus.sel_valid && !w_cancel_acc;
   assign w_sel_in_range = {1'b0, bus.sel} < (SEL_W+1)'(NUM_PROD);
   assign w_price        = price_of(PRICES_MAX_W'(PRICES), 32'(bus.sel), PRICE_W);
   assign w_price_ok     = 32'(r_credit) >= w_price;
   assign w_sold_ext     = SEL_SPAN'(w_sold_out);
   assign w_sel_ok       = w_sel_take && (r_state == ST_COLLECT) && w_sel_in_range &&
                           w_price_ok && !w_sold_ext[bus.sel];
   assign w_sel_bad      = w_sel_take && !w_sel_ok;
   assign w_chg_ok       = r_credit >= CREDIT_W'(CHG_UNIT);

   always_comb begin
      w_coin_val = '0;
      case (bus.coin)
         COIN_1:  w_coin_val = SUM_W'(COIN1_VAL);
         COIN_2:  w_coin_val = SUM_W'(COIN2_VAL);
         COIN_3:  w_coin_val = SUM_W'(COIN3_VAL);
         default: w_coin_val = '0;
      endcase
   end

   assign w_sum      = {1'b0, r_credit} + w_coin_val;
   // Coins lose to any selection in the same cycle, valid or refused.
   assign w_coin_acc = w_front && (bus.coin != COIN_NONE) && !w_cancel_acc &&
                       !w_sel_take && (w_sum <= SUM_W'(MAX_CREDIT));

   // Change train starts the cycle after cancel or VEND, only if a unit is owed.
   assign w_load = w_chg_ok && (w_cancel_acc || (r_state == ST_VEND));

   vm_change_dispenser #(
      .CREDIT_W (CREDIT_W),
      .CHG_UNIT (CHG_UNIT)
   ) u_chg (
      .clk      (clk),
      .reset    (reset),
      .i_load   (w_load),
      .i_amount (r_credit),
      .o_change (w_change),
      .o_done   (w_done)
   );

   // -------------------------------------------------------- state register
   always_ff @(posedge clk) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // ------------------------------------------------------------ next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_coin_acc) w_state_nxt = ST_COLLECT;
         end
         ST_COLLECT: begin
            if (w_cancel_acc)  w_state_nxt = w_chg_ok ? ST_CHANGE : ST_IDLE;
            else if (w_sel_ok) w_state_nxt = ST_VEND;
         end
         ST_VEND: begin
            w_state_nxt = w_chg_ok ? ST_CHANGE : ST_IDLE;
         end
         ST_CHANGE: begin
            if (w_done || !w_change) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // --------------------------------------------------------------- outputs
   always_comb begin
      w_busy        = (r_state == ST_VEND) || (r_state == ST_CHANGE);
      w_coin_reject = (bus.coin != COIN_NONE) && !w_coin_acc;
   end

   // ---------------------------------------------------------------- credit
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_credit <= '0;
      end else begin
         case (r_state)
            ST_IDLE, ST_COLLECT: begin
               if (w_cancel_acc) begin
                  if (!w_chg_ok) r_credit <= '0;
               end else if (w_sel_ok) begin
                  r_credit <= r_credit - CREDIT_W'(w_price);
               end else if (w_coin_acc) begin
                  r_credit <= CREDIT_W'(w_sum);
               end
            end
            ST_VEND: begin
               if (!w_chg_ok) r_credit <= '0;
            end
            ST_CHANGE: begin
               // Residue below one unit is dropped with the final pulse.
               if (w_change && !w_done) r_credit <= r_credit - CREDIT_W'(CHG_UNIT);
               else                     r_credit <= '0;
            end
            default: r_credit <= '0;
         endcase
      end
   end

   // ------------------------------------------------------ vend / sel_err
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_vend    <= '0;
         r_sel_err <= 1'b0;
      end else begin
         r_vend    <= w_sel_ok ? (NUM_PROD'(1) << bus.sel) : '0;
         r_sel_err <= w_sel_bad;
      end
   end

   // ----------------------------------------------------------------- stock
`ifdef VM_STOCK_TRACK_EN
   logic [STOCK_W-1:0] r_stock [NUM_PROD];

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NUM_PROD; i++) r_stock[i] <= STOCK_W'(STOCK_INIT);
      end else if ((r_state == ST_IDLE) && bus.restock) begin
         for (int i = 0; i < NUM_PROD; i++) r_stock[i] <= STOCK_W'(STOCK_INIT);
      end else if (w_sel_ok) begin
         for (int i = 0; i < NUM_PROD; i++) begin
            if ({1'b0, bus.sel} == (SEL_W+1)'(i)) r_stock[i] <= r_stock[i] - STOCK_W'(1);
         end
      end
   end

   always_comb begin
      w_sold_out = '0;
      for (int i = 0; i < NUM_PROD; i++) w_sold_out[i] = (r_stock[i] == '0);
   end
`else
   logic w_unused_restock;
   assign w_unused_restock = bus.restock;
   assign w_sold_out       = '0;
`endif

   assign bus.vend        = r_vend;
   assign bus.change      = w_change;
   assign bus.credit      = r_credit;
   assign bus.busy        = w_busy;
   assign bus.coin_reject = w_coin_reject;
   assign bus.sel_err     = r_sel_err;
   assign bus.sold_out    = w_sold_out;

endmodule

// File: tb/tb_vending_machine_param.sv
// -----------------------------------------------------------------------------
// tb_vending_machine_param
// Directed bench for vending_machine_param (default parameters). Expected vend
// vectors are queued when a selection is driven and popped when a vend pulse
// is seen; change pulses are counted as they appear.
// Define VM_STOCK_TRACK_EN for both bench and RTL to run the stock scenario
// (stock initialised to 1 per product).
// -----------------------------------------------------------------------------
module tb_vending_machine_param;
   import vm_pkg::*;

   localparam int NUM_PROD = 4;
   localparam int SEL_W    = 2;
   localparam int CREDIT_W = 8;
`ifdef VM_STOCK_TRACK_EN
   localparam int TB_STOCK_INIT = 1;
`else
   localparam int TB_STOCK_INIT = 8;
`endif

   logic clk = 1'b0;
   logic reset;
   bit   in_rst;
   int   n_checks = 0;
   int   n_errors = 0;
   int   chg_cnt  = 0;
   int   base;
   logic [NUM_PROD-1:0] exp_vend_q [$];

   vm_if #(.NUM_PROD(NUM_PROD), .SEL_W(SEL_W), .CREDIT_W(CREDIT_W)) bus ();

   vending_machine_param #(
      .NUM_PROD   (NUM_PROD),
      .SEL_W      (SEL_W),
      .CREDIT_W   (CREDIT_W),
      .STOCK_INIT (TB_STOCK_INIT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   // One clock: wait past the falling edge, then score vend and change pulses.
   task automatic step();
      @(negedge clk);
      #1;
      if (!in_rst) begin
         if (bus.change === 1'b1) chg_cnt++;
         if (bus.vend !== '0) begin
            if (exp_vend_q.size() == 0) chk("vend_unexpected", 32'(bus.vend), 0);
            else                        chk("vend", 32'(bus.vend), 32'(exp_vend_q.pop_front()));
         end
      end
   endtask

   task automatic insert(input logic [1:0] code, input logic exp_rej, input int exp_credit);
      bus.coin = code;
      #1;
      chk("coin_reject", 32'(bus.coin_reject), 32'(exp_rej));
      step();
      bus.coin = COIN_NONE;
      chk("credit_after_coin", 32'(bus.credit), 32'(exp_credit));
   endtask

   task automatic select(input logic [SEL_W-1:0] idx, input logic [NUM_PROD-1:0] exp_vend);
      bus.sel_valid = 1'b1;
      bus.sel       = idx;
      if (exp_vend != '0) exp_vend_q.push_back(exp_vend);
      step();
      bus.sel_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      for (int k = 0; k < 100; k++) begin
         if (bus.busy === 1'b0) break;
         step();
      end
      chk(tag, 32'(bus.busy), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset         = 1'b0;
      in_rst        = 1'b1;
      bus.coin      = COIN_NONE;
      bus.sel_valid = 1'b0;
      bus.sel       = '0;
      bus.cancel    = 1'b0;
      bus.restock   = 1'b0;
      step();
      step();
      chk("rst_credit",   32'(bus.credit),   0);
      chk("rst_busy",     32'(bus.busy),     0);
      chk("rst_vend",     32'(bus.vend),     0);
      chk("rst_change",   32'(bus.change),   0);
      chk("rst_sel_err",  32'(bus.sel_err),  0);
      chk("rst_sold_out", 32'(bus.sold_out), 0);
      reset  = 1'b1;
      in_rst = 1'b0;

      // 1: exact payment, no change
      insert(COIN_1, 1'b0, 5);
      insert(COIN_2, 1'b0, 15);
      base = chg_cnt;
      select(2'd1, 4'b0010);
      chk("t1_vend_busy",   32'(bus.busy),   1);
      chk("t1_vend_credit", 32'(bus.credit), 0);
      step();
      chk("t1_vend_1cyc", 32'(bus.vend),   0);
      chk("t1_idle_busy", 32'(bus.busy),   0);
      chk("t1_credit",    32'(bus.credit), 0);
      chk("t1_no_change", chg_cnt - base,  0);

      // 2: overpay, three change pulses
      insert(COIN_3, 1'b0, 25);
      base = chg_cnt;
      select(2'd0, 4'b0001);
      chk("t2_vend_credit", 32'(bus.credit), 15);
      chk("t2_vend_busy",   32'(bus.busy),   1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t2_change",     32'(bus.change), 1);
         chk("t2_chg_busy",   32'(bus.busy),   1);
         chk("t2_chg_credit", 32'(bus.credit), 32'(15 - 5 * i));
      end
      step();
      chk("t2_idle_busy",   32'(bus.busy),   0);
      chk("t2_idle_change", 32'(bus.change), 0);
      chk("t2_credit",      32'(bus.credit), 0);
      chk("t2_pulses",      chg_cnt - base,  3);

      // 3: insufficient credit, then cancel
      insert(COIN_1, 1'b0, 5);
      select(2'd3, '0);
      chk("t3_sel_err",     32'(bus.sel_err), 1);
      chk("t3_credit_kept", 32'(bus.credit),  5);
      chk("t3_not_busy",    32'(bus.busy),    0);
      step();
      chk("t3_sel_err_1cyc", 32'(bus.sel_err), 0);
      base = chg_cnt;
      bus.cancel = 1'b1;
      step();
      bus.cancel = 1'b0;
      chk("t3_change",     32'(bus.change), 1);
      chk("t3_chg_credit", 32'(bus.credit), 5);
      step();
      chk("t3_idle_busy", 32'(bus.busy),   0);
      chk("t3_credit",    32'(bus.credit), 0);
      chk("t3_pulses",    chg_cnt - base,  1);

      // selection with no credit
      select(2'd0, '0);
      chk("idle_sel_err",    32'(bus.sel_err), 1);
      chk("idle_sel_credit", 32'(bus.credit),  0);

      // 4: credit saturation and coin lost to a selection
      for (int i = 1; i <= 10; i++) insert(COIN_3, 1'b0, 25 * i);
      insert(COIN_3, 1'b1, 250);
      bus.coin      = COIN_3;
      bus.sel_valid = 1'b1;
      bus.sel       = 2'd0;
      #1;
      chk("t4_coin_vs_sel", 32'(bus.coin_reject), 1);
      exp_vend_q.push_back(4'b0001);
      step();
      bus.coin      = COIN_NONE;
      bus.sel_valid = 1'b0;
      chk("t4_vend_credit", 32'(bus.credit), 240);
      base = chg_cnt;
      wait_idle("t4_idle");
      chk("t4_pulses", chg_cnt - base,  48);
      chk("t4_credit", 32'(bus.credit), 0);

      // 5: reset during the second change pulse
      insert(COIN_3, 1'b0, 25);
      base = chg_cnt;
      select(2'd0, 4'b0001);
      step();
      step();
      chk("t5_pulse2",        32'(bus.change), 1);
      chk("t5_pulse2_credit", 32'(bus.credit), 10);
      reset = 1'b0;
      step();
      chk("t5_rst_change", 32'(bus.change), 0);
      chk("t5_rst_credit", 32'(bus.credit), 0);
      chk("t5_rst_busy",   32'(bus.busy),   0);
      reset = 1'b1;
      step();
      step();
      chk("t5_pulses", chg_cnt - base, 2);
      chk("t5_busy",   32'(bus.busy),  0);

`ifdef VM_STOCK_TRACK_EN
      // 6: sell out product 2, then restock
      insert(COIN_3, 1'b0, 25);
      select(2'd2, 4'b0100);
      chk("t6_vend_credit", 32'(bus.credit),   5);
      chk("t6_sold_out",    32'(bus.sold_out), 32'h4);
      wait_idle("t6_idle1");
      insert(COIN_3, 1'b0, 25);
      select(2'd2, '0);
      chk("t6_sel_err",  32'(bus.sel_err),  1);
      chk("t6_credit",   32'(bus.credit),   25);
      chk("t6_sold_out2", 32'(bus.sold_out), 32'h4);
      bus.cancel = 1'b1;
      step();
      bus.cancel = 1'b0;
      wait_idle("t6_idle2");
      bus.restock = 1'b1;
      step();
      bus.restock = 1'b0;
      chk("t6_restock", 32'(bus.sold_out), 0);
`else
      bus.restock = 1'b1;
      step();
      bus.restock = 1'b0;
      chk("restock_ignored", 32'(bus.sold_out), 0);
`endif

      chk("vend_queue_empty", 32'(exp_vend_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
